// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: sequential advance, stall, redirect,
// call/return via a circular return-address stack, and trap entry/exit.
module pc_gen #(
    parameter int                ADDR_W     = 6,
    parameter int                STEP       = 2,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 6'h00,
    parameter logic [ADDR_W-1:0] TRAP_ADDR  = 6'h30,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              resetIn,
    input  logic              enable,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectAddr,
    input  logic              call,
    input  logic              ret,
    input  logic              trap,
    input  logic              trapRet,
    output logic [ADDR_W-1:0] addrOut,
    output logic [ADDR_W-1:0] epcOut,
    output logic              rasEmpty,
    output logic              rasFull,
    output logic              rasOverflow,
    output logic              rasUnderflow
);

    localparam int                PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STEP);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
    logic              push_s;
    logic [ADDR_W-1:0] seq_pc_s;
    logic [PTR_W-1:0]  pop_idx_s;

    // ptr_q is the next free slot; the newest entry sits one below it.
    assign seq_pc_s  = pc_q + STEP_A;
    assign pop_idx_s = ptr_q - PTR_ONE;

    // Next-state selection by fixed priority: trap, trapRet, ret, redirect, advance.
    always_comb begin
        pc_d   = pc_q;
        epc_d  = epc_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        push_s = 1'b0;
        if (trap) begin
            pc_d  = TRAP_ADDR;
            epc_d = pc_q;
        end else if (enable) begin
            if (trapRet) begin
                pc_d = epc_q;
            end else if (ret) begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    pc_d  = ras_mem_q[pop_idx_s];
                    ptr_d = pop_idx_s;
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    pc_d  = seq_pc_s;
                    unf_d = 1'b1;
                end
            end else if (redirect) begin
                pc_d = redirectAddr;
                if (call) begin
                    push_s = 1'b1;
                    ptr_d  = ptr_q + PTR_ONE;
                    if (cnt_q == DEPTH_C) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    push_s = 1'b0;
                end
            end else begin
                pc_d = seq_pc_s;
            end
        end else begin
            pc_d = pc_q;
        end
        empty_d = (cnt_d == {CNT_W{1'b0}});
        full_d  = (cnt_d == DEPTH_C);
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            pc_q    <= RESET_ADDR;
            epc_q   <= RESET_ADDR;
            ptr_q   <= {PTR_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            ras_mem_q[ptr_q] <= seq_pc_s;
        end
    end

    assign addrOut      = pc_q;
    assign epcOut       = epc_q;
    assign rasEmpty     = empty_q;
    assign rasFull      = full_q;
    assign rasOverflow  = ovf_q;
    assign rasUnderflow = unf_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequential/stall/wrap, call/return, RAS limits,
// trap entry/exit, priority collisions and asynchronous reset.
module tb_pc_gen;

    logic       clk = 1'b0;
    logic       resetIn;
    logic       enable;
    logic       redirect;
    logic [5:0] redirectAddr;
    logic       call;
    logic       ret;
    logic       trap;
    logic       trapRet;
    logic [5:0] addrOut;
    logic [5:0] epcOut;
    logic       rasEmpty;
    logic       rasFull;
    logic       rasOverflow;
    logic       rasUnderflow;

    int n_total = 0;
    int n_bad   = 0;

    pc_gen #(
        .ADDR_W(6), .STEP(2), .RESET_ADDR(6'h00), .TRAP_ADDR(6'h30), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .resetIn(resetIn), .enable(enable), .redirect(redirect),
        .redirectAddr(redirectAddr), .call(call), .ret(ret), .trap(trap),
        .trapRet(trapRet), .addrOut(addrOut), .epcOut(epcOut),
        .rasEmpty(rasEmpty), .rasFull(rasFull), .rasOverflow(rasOverflow),
        .rasUnderflow(rasUnderflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        redirect = 1'b0; call = 1'b0; ret = 1'b0; trap = 1'b0; trapRet = 1'b0;
    endtask

    task automatic do_call(input logic [5:0] tgt);
        redirect = 1'b1; call = 1'b1; redirectAddr = tgt;
        cyc();
        idle();
    endtask

    task automatic do_jump(input logic [5:0] tgt);
        redirect = 1'b1; call = 1'b0; redirectAddr = tgt;
        cyc();
        idle();
    endtask

    initial begin
        resetIn = 1'b0; enable = 1'b0; redirectAddr = 6'h00;
        idle();
        #12;
        check_eq("rst_addr",  addrOut, 0);
        check_eq("rst_epc",   epcOut, 0);
        check_eq("rst_empty", rasEmpty, 1);
        check_eq("rst_full",  rasFull, 0);
        check_eq("rst_ovf",   rasOverflow, 0);
        check_eq("rst_unf",   rasUnderflow, 0);

        // 1: sequential, stall, wrap
        @(negedge clk);
        resetIn = 1'b1; enable = 1'b1;
        cyc(); check_eq("seq1", addrOut, 2);
        cyc(); check_eq("seq2", addrOut, 4);
        cyc(); check_eq("seq3", addrOut, 6);
        enable = 1'b0;
        redirect = 1'b1; redirectAddr = 6'h3C;
        cyc(); check_eq("stall1_drop_redirect", addrOut, 6);
        redirect = 1'b0;
        cyc(); check_eq("stall2", addrOut, 6);
        enable = 1'b1;
        do_jump(6'h3E); check_eq("jump_3e", addrOut, 6'h3E);
        cyc(); check_eq("wrap", addrOut, 6'h00);

        // 2: call / return
        cyc(); cyc(); check_eq("pc4", addrOut, 4);
        do_call(6'h20);
        check_eq("call_tgt", addrOut, 6'h20);
        check_eq("call_nonempty", rasEmpty, 0);
        ret = 1'b1; cyc(); ret = 1'b0;
        check_eq("ret_addr", addrOut, 6);
        check_eq("ret_empty", rasEmpty, 1);

        // 3: overflow / underflow
        do_jump(6'h00);
        do_call(6'd8);  check_eq("c1_full", rasFull, 0);
        do_call(6'd16);
        do_call(6'd24); check_eq("c3_full", rasFull, 0);
        do_call(6'd32);
        check_eq("c4_full", rasFull, 1);
        check_eq("c4_ovf", rasOverflow, 0);
        do_call(6'h3A);
        check_eq("c5_ovf", rasOverflow, 1);
        check_eq("c5_full", rasFull, 1);
        check_eq("c5_addr", addrOut, 6'h3A);
        ret = 1'b1;
        cyc(); check_eq("r1", addrOut, 34); check_eq("r1_ovf_clear", rasOverflow, 0);
        cyc(); check_eq("r2", addrOut, 26);
        cyc(); check_eq("r3", addrOut, 18);
        cyc(); check_eq("r4", addrOut, 10); check_eq("r4_empty", rasEmpty, 1);
        cyc(); check_eq("r5_addr", addrOut, 12); check_eq("r5_unf", rasUnderflow, 1);
        ret = 1'b0;
        cyc(); check_eq("unf_clear", rasUnderflow, 0); check_eq("after_unf", addrOut, 14);

        // 4: trap
        do_jump(6'h0A);
        enable = 1'b0; trap = 1'b1;
        cyc(); idle();
        check_eq("trap_addr", addrOut, 6'h30);
        check_eq("trap_epc", epcOut, 6'h0A);
        enable = 1'b1;
        cyc(); check_eq("in_handler", addrOut, 6'h32);
        trapRet = 1'b1; cyc(); idle();
        check_eq("trapret_addr", addrOut, 6'h0A);
        check_eq("trapret_epc_kept", epcOut, 6'h0A);
        trap = 1'b1; redirect = 1'b1; redirectAddr = 6'h3C;
        cyc(); idle();
        check_eq("trap_wins", addrOut, 6'h30);
        check_eq("trap_wins_epc", epcOut, 6'h0A);
        cyc(); check_eq("handler2", addrOut, 6'h32);
        enable = 1'b0; trapRet = 1'b1;
        cyc(); idle();
        check_eq("trapret_stalled", addrOut, 6'h32);
        enable = 1'b1;

        // 5: ret + redirect + call collision
        do_jump(6'h10);
        do_call(6'h20);
        ret = 1'b1; redirect = 1'b1; call = 1'b1; redirectAddr = 6'h3C;
        cyc(); idle();
        check_eq("collide_addr", addrOut, 6'h12);
        check_eq("collide_empty", rasEmpty, 1);
        ret = 1'b1; cyc(); ret = 1'b0;
        check_eq("collide_nopush_unf", rasUnderflow, 1);
        check_eq("collide_nopush_addr", addrOut, 6'h14);

        // 6: asynchronous reset between edges
        do_call(6'h18);
        do_call(6'h20);
        check_eq("pre_rst_addr", addrOut, 6'h20);
        check_eq("pre_rst_empty", rasEmpty, 0);
        enable = 1'b0;
        #2;
        resetIn = 1'b0;
        #1;
        check_eq("arst_addr", addrOut, 0);
        check_eq("arst_epc", epcOut, 0);
        check_eq("arst_empty", rasEmpty, 1);
        enable = 1'b1;
        @(negedge clk);
        resetIn = 1'b1;
        cyc(); check_eq("post_rst_seq", addrOut, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage; drives the instruction ROM address. It supports sequential advance, stall, and jump/branch redirect. It also provides call/return through an internal return-address stack (RAS) and trap entry/exit with a saved exception PC. All state is registered, and every request is resolved by a fixed priority in a single cycle.

## Interface
Parameters:
- ADDR_W, 6: address width.
- STEP, 2: sequential increment, in address units.
- RESET_ADDR, 0: PC value after reset.
- TRAP_ADDR, 6'h30: trap vector.
- RAS_DEPTH, 4: return-address-stack entries; must be a power of two, ≥2.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- resetIn  in  1  one clock; reset is asynchronous and active-low.
- enable  in  1  advance permitted; 0 = stall. Trap ignores it.
- redirect  in  1  take redirectAddr (jump/branch).
- redirectAddr  in  ADDR_W  redirect target.
- call  in  1  qualifies redirect: also push the return address. Ignored without redirect.
- ret  in  1  pop the RAS into the PC.
- trap  in  1  enter trap: save the PC and go to TRAP_ADDR.
- trapRet  in  1  return from trap to epcOut.
- addrOut  out  ADDR_W  current PC, to ROM.
- epcOut  out  ADDR_W  saved exception PC.
- rasEmpty  out  1  RAS holds 0 entries.
- rasFull  out  1  RAS holds RAS_DEPTH entries.
- rasOverflow  out  1  one-cycle pulse: push while full.
- rasUnderflow  out  1  one-cycle pulse: pop while empty.

## Operation
Next-PC priority, highest first; exactly one action per cycle:
1. trap: addrOut←TRAP_ADDR, epcOut←addrOut. Taken even when enable=0.
2. trapRet (enable=1): addrOut←epcOut.
3. ret (enable=1):
   - RAS non-empty: addrOut←top entry, pop.
   - RAS empty: addrOut←addrOut+STEP, rasUnderflow=1.
4. redirect (enable=1): addrOut←redirectAddr.
   - If call=1, also push addrOut+STEP.
5. enable=1, no request: addrOut←addrOut+STEP.
6. enable=0: all state holds; every request except trap is dropped, not queued.

A lower-priority request in the same cycle is discarded. For example, trap+redirect produces trap only, and ret+redirect+call produces a pop only, with no push.

RAS:
- Circular buffer with top pointer and count (0..RAS_DEPTH).
- Push while full: overwrites the oldest entry, count stays RAS_DEPTH, pointer advances, rasOverflow=1.
- Pop: returns the newest entry; count decrements.

Arithmetic: all address sums are modulo 2^ADDR_W. Wrap is silent, e.g. 6'h3E+2 → 6'h00.

epcOut changes only on trap. trapRet does not clear it. Nested traps overwrite it.

## Timing
- All outputs are registered. A request sampled at edge N is visible on addrOut/epcOut/flags after edge N, so redirect latency is 1 cycle.
- rasEmpty/rasFull reflect the count after the edge.
- rasOverflow/rasUnderflow are high for exactly the one cycle following the offending edge, then return to 0.
- Reset (resetIn=0), taking effect immediately and independent of clk:
  - addrOut=RESET_ADDR, epcOut=RESET_ADDR.
  - RAS count=0, pointer=0, so rasEmpty=1 and rasFull=0.
  - rasOverflow=0, rasUnderflow=0.
  - RAS entry contents are don't-care.
- Reset asserted mid-operation aborts any pending action. The first edge after release performs a normal priority evaluation from RESET_ADDR.
- No combinational path from any input to any output.

## Test plan
Parameters for all scenarios: ADDR_W=6, STEP=2, RESET_ADDR=0, TRAP_ADDR=6'h30, RAS_DEPTH=4.
1. Reset and sequential/stall/wrap:
   - Release reset, enable=1 for 3 cycles → addrOut 0,2,4,6.
   - enable=0 for 2 cycles → addrOut holds 6.
   - Force PC to 6'h3E via redirect, then enable → addrOut=6'h00.
2. Call/return:
   - At PC 4, redirect=1 call=1 redirectAddr=6'h20 → addrOut=6'h20, rasEmpty=0.
   - Next cycle ret=1 → addrOut=6.
   - Then rasEmpty=1.
3. RAS overflow/underflow:
   - 5 calls from PCs 0,8,16,24,32 (targets arbitrary) → rasFull=1 after the 4th; rasOverflow pulses once on the 5th.
   - 4 rets → addrOut 34,26,18,10; the return address 2 was overwritten.
   - 5th ret → addrOut=prev+2, rasUnderflow pulse.
4. Trap:
   - At PC 6'h0A with enable=0, assert trap → addrOut=6'h30, epcOut=6'h0A.
   - Later trapRet → addrOut=6'h0A.
   - trap+redirect in the same cycle → trap wins.
5. Priority collision: ret+redirect+call with RAS holding 6'h12 → addrOut=6'h12, RAS count decremented by 1, no push.
6. Async reset mid-operation: assert resetIn=0 between edges with PC=6'h20 and RAS count=2 → addrOut=0, epcOut=0, rasEmpty=1 before the next clk edge.
